// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Purpose  : Shared types for the data-memory arbiter. It defines the lock
//            FSM state encoding and the read-response owner encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  // Debug burst-lock FSM states.
  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // Owner of an outstanding read response.
  typedef logic owner_t;
  localparam owner_t OWN_CORE = 1'b0;
  localparam owner_t OWN_DBG  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter with a synchronous clear. Clear takes
//            priority over increment. At the maximum value the counter holds
//            and does not wrap.
// Ports    : clk    - clock, rising edge
//            reset  - asynchronous active-low reset, forces count to 0
//            inc    - increment request for this cycle
//            clr    - synchronous clear, overrides inc
//            count  - current count value
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-requester arbiter in front of a single-port data memory.
//            The core and the debug/loader port compete for access. Grants
//            are combinational in the request cycle. On a conflict the
//            requester that was not granted last wins. The debug port can
//            lock the memory for bursts. Read data returns one cycle after
//            the grant and is steered to the owner of the request. The
//            counter stall_cnt counts the cycles in which the core was stalled.
// Ports    : clk, reset          - clock and async active-low reset
//            c_req/c_we/c_addr/c_wdata   - core request
//            c_gnt/c_stall               - core grant, stall (PC hold enable)
//            c_rvalid/c_rdata            - core read response
//            d_req/d_we/d_lock/d_addr/d_wdata - debug request and burst lock
//            d_gnt/d_rvalid/d_rdata      - debug grant and read response
//            mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - memory port
//            stall_cnt/stall_clr         - core stall counter and its clear
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  // core side
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  // debug / loader side
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // stall performance counter
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  lock_state_t r_state;
  lock_state_t w_state_next;

  logic   r_last_d;      // 1 = debug held the most recent grant
  logic   r_rsp_valid;   // a read was granted last cycle
  owner_t r_rsp_owner;

  logic   w_c_gnt;
  logic   w_d_gnt;
  logic   w_lock_hold;   // locked and debug still holds the lock
  logic   w_rd_issue;

  // --------------------------------------------------------------------------
  // Lock FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= UNLOCKED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Lock FSM: grant and next-state logic
  // While the lock is held, only debug may be granted. When d_lock drops, the
  // same cycle is arbitrated as unlocked, so the core can win at once.
  // --------------------------------------------------------------------------
  always_comb begin
    w_c_gnt      = 1'b0;
    w_d_gnt      = 1'b0;
    w_lock_hold  = 1'b0;
    w_state_next = r_state;

    unique case (r_state)
      LOCKED: begin
        if (d_lock) begin
          w_lock_hold = 1'b1;
          w_d_gnt     = d_req;
        end
      end
      UNLOCKED: begin
      end
    endcase

    if (!w_lock_hold) begin
      if (c_req && d_req) begin
        // Round robin: the side that was not granted last wins.
        w_c_gnt = r_last_d;
        w_d_gnt = ~r_last_d;
      end else begin
        w_c_gnt = c_req;
        w_d_gnt = d_req;
      end
      w_state_next = (w_d_gnt && d_lock) ? LOCKED : UNLOCKED;
    end
  end

  assign c_gnt   = w_c_gnt;
  assign d_gnt   = w_d_gnt;
  assign c_stall = c_req & ~w_c_gnt;

  // The memory must never be enabled while reset is active, even though the
  // grant outputs are still computed from the reset state.
  assign mem_en    = (w_c_gnt | w_d_gnt) & reset;
  assign mem_we    = w_d_gnt ? d_we    : c_we;
  assign mem_addr  = w_d_gnt ? d_addr  : c_addr;
  assign mem_wdata = w_d_gnt ? d_wdata : c_wdata;

  assign w_rd_issue = mem_en & ~mem_we;

  // --------------------------------------------------------------------------
  // Round-robin pointer and read-response tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_d    <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= OWN_CORE;
    end else begin
      if (w_c_gnt || w_d_gnt) begin
        r_last_d <= w_d_gnt;
      end
      r_rsp_valid <= w_rd_issue;
      if (w_rd_issue) begin
        r_rsp_owner <= w_d_gnt ? OWN_DBG : OWN_CORE;
      end
    end
  end

  assign c_rvalid = r_rsp_valid && (r_rsp_owner == OWN_CORE);
  assign d_rvalid = r_rsp_valid && (r_rsp_owner == OWN_DBG);
  // The requester that does not own the response sees zero data.
  assign c_rdata  = c_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  // --------------------------------------------------------------------------
  // Core stall counter
  // --------------------------------------------------------------------------
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (c_stall),
    .clr   (stall_clr),
    .count (stall_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter. A memory model sits behind
//            the DUT. A behavioural reference model is checked on every
//            falling edge, and directed sequences add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, d_req, d_we, d_lock, stall_clr;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] c_rdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  // Memory behind the DUT: 16 words, one-cycle read latency. Junk is returned
  // when no read is issued, so that missing rdata gating can be seen.
  logic [DW-1:0] tmem [16] = '{default: '0};
  always @(posedge clk) begin
    if (mem_en && mem_we) tmem[mem_addr[5:2]] <= mem_wdata;
    mem_rdata <= (mem_en && !mem_we) ? tmem[mem_addr[5:2]] : 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic          m_last_d = 1'b1;   // debug was granted most recently
  logic          m_locked = 1'b0;
  logic          m_pend   = 1'b0;
  logic          m_pown   = 1'b0;   // 1 = debug owns pending response
  logic [DW-1:0] m_pdata  = '0;
  int            m_cnt    = 0;
  logic [DW-1:0] mmem [16] = '{default: '0};

  always @(negedge clk) begin : model_check
    logic hold, eg_c, eg_d, any, swe;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    if (!reset) begin
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_c_rvalid", 32'(c_rvalid), 0);
      chk("rst_d_rvalid", 32'(d_rvalid), 0);
      chk("rst_c_rdata", c_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
      m_last_d = 1'b1; m_locked = 1'b0; m_pend = 1'b0; m_cnt = 0;
    end else begin
      // response due this cycle
      chk("c_rvalid", 32'(c_rvalid), 32'(m_pend && !m_pown));
      chk("d_rvalid", 32'(d_rvalid), 32'(m_pend && m_pown));
      if (m_pend && !m_pown) begin
        chk("c_rdata", c_rdata, m_pdata);
        chk("d_rdata_nonowner", d_rdata, 0);
      end
      if (m_pend && m_pown) begin
        chk("d_rdata", d_rdata, m_pdata);
        chk("c_rdata_nonowner", c_rdata, 0);
      end
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      // arbitration rules
      hold = m_locked && d_lock;
      if (hold) begin
        eg_c = 1'b0; eg_d = d_req;
      end else if (c_req && d_req) begin
        eg_c = m_last_d; eg_d = !m_last_d;
      end else begin
        eg_c = c_req; eg_d = d_req;
      end
      any = eg_c || eg_d;
      chk("c_gnt", 32'(c_gnt), 32'(eg_c));
      chk("d_gnt", 32'(d_gnt), 32'(eg_d));
      chk("c_stall", 32'(c_stall), 32'(c_req && !eg_c));
      chk("mem_en", 32'(mem_en), 32'(any));
      swe = eg_d ? d_we : c_we;
      sa  = eg_d ? d_addr : c_addr;
      sd  = eg_d ? d_wdata : c_wdata;
      if (any) begin
        chk("mem_we", 32'(mem_we), 32'(swe));
        chk("mem_addr", mem_addr, sa);
        if (swe) chk("mem_wdata", mem_wdata, sd);
      end
      // advance model to the next cycle
      if (any) m_last_d = eg_d;
      m_locked = hold ? 1'b1 : (eg_d && d_lock);
      m_pend   = any && !swe;
      m_pown   = eg_d;
      m_pdata  = mmem[sa[5:2]];
      if (any && swe) mmem[sa[5:2]] = sd;
      if (stall_clr) m_cnt = 0;
      else if (c_req && !eg_c) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic setc(input logic rq, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    c_req = rq; c_we = we; c_addr = a; c_wdata = wd;
  endtask

  task automatic setd(input logic rq, input logic we, input logic lk, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd);
    d_req = rq; d_we = we; d_lock = lk; d_addr = a; d_wdata = wd;
  endtask

  task automatic idle;
    setc(0, 0, 0, 0); setd(0, 0, 0, 0, 0); stall_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    // reset with a core request pending: memory must stay disabled
    setc(1, 0, 32'h4, 0);
    @(negedge clk);
    chk("lit_rst_mem_en", 32'(mem_en), 0);
    tick(); tick();
    reset = 1'b1;
    idle();
    tick();

    // core write 16 to 0x0, then read 0x0
    setc(1, 1, 32'h0, 32'd16);
    @(negedge clk); chk("lit_wr_c_gnt", 32'(c_gnt), 1);
    tick();
    setc(1, 0, 32'h0, 0);
    @(negedge clk); chk("lit_rd_c_gnt", 32'(c_gnt), 1);
    tick();
    idle();
    @(negedge clk);
    chk("lit_rd_c_rvalid", 32'(c_rvalid), 1);
    chk("lit_rd_c_rdata", c_rdata, 32'd16);
    tick();

    // conflict from reset: core, debug, core
    reset = 1'b0; tick(); reset = 1'b1; tick();
    setc(1, 0, 32'h4, 0); setd(1, 0, 0, 32'h8, 0);
    @(negedge clk); chk("lit_cf1_c_gnt", 32'(c_gnt), 1); chk("lit_cf1_c_stall", 32'(c_stall), 0);
    tick();
    @(negedge clk); chk("lit_cf2_d_gnt", 32'(d_gnt), 1); chk("lit_cf2_c_stall", 32'(c_stall), 1);
    tick();
    @(negedge clk); chk("lit_cf3_c_gnt", 32'(c_gnt), 1); chk("lit_cf3_d_rvalid", 32'(d_rvalid), 1);
    tick();
    idle();
    @(negedge clk); chk("lit_cf_stall_cnt", 32'(stall_cnt), 1);
    tick();

    // debug lock burst: 4 locked writes while core waits, then unlock
    stall_clr = 1'b1; tick(); stall_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setc(1, 0, 32'h0, 0);
      setd(1, 1, 1, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i));
      @(negedge clk);
      chk("lit_lk_d_gnt", 32'(d_gnt), 1);
      chk("lit_lk_c_gnt", 32'(c_gnt), 0);
      tick();
    end
    setd(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lit_lk_stall_cnt", 32'(stall_cnt), 4);
    chk("lit_unlk_c_gnt", 32'(c_gnt), 1);
    tick();

    // saturation: core stalled 20 cycles under a debug read lock
    idle(); stall_clr = 1'b1; tick(); stall_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      setc(1, 0, 32'h0, 0); setd(1, 0, 1, 32'h20, 0);
      tick();
    end
    stall_clr = 1'b1;   // clear while still stalling: clear must win
    @(negedge clk); chk("lit_sat_stall_cnt", 32'(stall_cnt), CMAX);
    tick();
    idle();
    @(negedge clk); chk("lit_clr_stall_cnt", 32'(stall_cnt), 0);
    tick();

    // locked with debug idle: core still held off
    setd(1, 1, 1, 32'h30, 32'h55);
    tick();
    setd(0, 0, 1, 0, 0); setc(1, 0, 32'h0, 0);
    @(negedge clk); chk("lit_lkidle_c_gnt", 32'(c_gnt), 0);
    tick();
    setd(0, 0, 0, 0, 0);
    @(negedge clk); chk("lit_lkrel_c_gnt", 32'(c_gnt), 1);
    tick();

    // interleaved: debug read 0x10 then core read 0x0
    idle(); setd(1, 0, 0, 32'h10, 0);
    tick();
    setd(0, 0, 0, 0, 0); setc(1, 0, 32'h0, 0);
    @(negedge clk); chk("lit_il_d_rvalid", 32'(d_rvalid), 1); chk("lit_il_d_rdata", d_rdata, 32'hA0);
    tick();
    idle();
    @(negedge clk); chk("lit_il_c_rvalid", 32'(c_rvalid), 1); chk("lit_il_c_rdata", c_rdata, 32'd16);
    tick();

    // back-to-back core reads
    for (int i = 0; i < 3; i++) begin
      setc(1, 0, 32'(4 * i), 0);
      tick();
    end
    idle(); tick();

    // reset during an outstanding read
    setc(1, 0, 32'h0, 0); setd(1, 0, 0, 32'h8, 0);   // core wins: last grant was core? model decides
    tick();
    idle(); reset = 1'b0;
    @(negedge clk);
    chk("lit_mr_c_rvalid", 32'(c_rvalid), 0); chk("lit_mr_d_rvalid", 32'(d_rvalid), 0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("lit_mr_post_c_rvalid", 32'(c_rvalid), 0); chk("lit_mr_post_d_rvalid", 32'(d_rvalid), 0);
    chk("lit_mr_stall_cnt", 32'(stall_cnt), 0);
    tick();
    setc(1, 0, 32'h4, 0); setd(1, 0, 0, 32'h8, 0);
    @(negedge clk); chk("lit_mr_conf_c_gnt", 32'(c_gnt), 1);
    tick();
    idle(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
